// File: rtl/serial_add_arb_if.sv
// Request/grant/result bundle between the two requesting units and the
// shared bit-serial adder controller.
interface serial_add_arb_if #(
  parameter int WIDTH = 8
);
  logic             req0;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic             req1;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             gnt0;
  logic             gnt1;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             owner;

  // Requester side: drives requests and operands, observes grants and results.
  modport master (
    output req0, a0, b0, req1, a1, b1,
    input  gnt0, gnt1, busy, done, result, cout, owner
  );

  // Adder controller side.
  modport slave (
    input  req0, a0, b0, req1, a1, b1,
    output gnt0, gnt1, busy, done, result, cout, owner
  );
endinterface

// File: rtl/serial_add_arb.sv
// Round-robin arbiter in front of a single shared full-adder slice.
// The winner's operands are added LSB-first over WIDTH cycles; sum, carry-out
// and owner are published together with a one-cycle done strobe.
module serial_add_arb #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  serial_add_arb_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             own;
  logic             ptr;     // requester served last; 1 after reset so req0 wins a tie

  logic             any_req;
  logic             pick1;
  logic [1:0]       ha0;
  logic [1:0]       ha1;
  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] sr_next;

  // Half adder packed as {carry, sum}.
  function automatic logic [1:0] half_add(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  // Full-adder slice built from two half adders and an OR on the carries.
  always_comb begin
    ha0     = half_add(sa[0], sb[0]);
    ha1     = half_add(ha0[0], carry);
    fa_sum  = ha1[0];
    fa_cout = ha0[1] | ha1[1];
    sr_next = {fa_sum, sr[WIDTH-1:1]};
  end

  // Round-robin pick: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    any_req = bus.req0 | bus.req1;
    pick1   = 1'b0;
    if (bus.req0 && bus.req1) pick1 = ~ptr;
    else if (bus.req1)        pick1 = 1'b1;
  end

  // Controller FSM with registered outputs; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sa         <= '0;
      sb         <= '0;
      sr         <= '0;
      carry      <= 1'b0;
      cnt        <= '0;
      own        <= 1'b0;
      ptr        <= 1'b1;
      bus.gnt0   <= 1'b0;
      bus.gnt1   <= 1'b0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.result <= '0;
      bus.cout   <= 1'b0;
      bus.owner  <= 1'b0;
    end else begin
      bus.gnt0 <= 1'b0;
      bus.gnt1 <= 1'b0;
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            sa       <= pick1 ? bus.a1 : bus.a0;
            sb       <= pick1 ? bus.b1 : bus.b0;
            carry    <= 1'b0;
            cnt      <= '0;
            own      <= pick1;
            ptr      <= pick1;
            bus.gnt0 <= ~pick1;
            bus.gnt1 <= pick1;
            bus.busy <= 1'b1;
            state    <= ADD;
          end
        end
        ADD: begin
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          sr    <= sr_next;
          carry <= fa_cout;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            bus.result <= sr_next;
            bus.cout   <= fa_cout;
            bus.owner  <= own;
            bus.done   <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_add_arb.sv
// Directed and randomised checks for the shared bit-serial adder arbiter.
module tb_serial_add_arb;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  serial_add_arb_if #(.WIDTH(WIDTH)) bus ();

  serial_add_arb #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request from a single requester starting in the current (idle)
  // cycle and observe it until done; returns to an idle cycle afterwards.
  task automatic do_op(input logic sel, input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] r, output logic c, output logic o,
                       output logic gs, output int gcyc, output int dcyc,
                       output int bcnt, output int viol);
    logic [7:0] prev_r;
    logic       prev_c;
    logic       prev_o;
    gcyc = -1; dcyc = -1; bcnt = 0; viol = 0;
    r = 8'h00; c = 1'b0; o = 1'b0; gs = 1'b0;
    prev_r = bus.result; prev_c = bus.cout; prev_o = bus.owner;
    if (sel) begin bus.req1 = 1'b1; bus.a1 = a; bus.b1 = b; end
    else     begin bus.req0 = 1'b1; bus.a0 = a; bus.b0 = b; end
    for (int cyc = 1; cyc <= 30 && dcyc < 0; cyc++) begin
      tick();
      if (bus.busy) bcnt++;
      if (bus.gnt0 && bus.gnt1) viol++;
      if (bus.done && (bus.gnt0 || bus.gnt1)) viol++;
      if ((bus.gnt0 || bus.gnt1) && gcyc < 0) begin
        gcyc = cyc; gs = bus.gnt1; bus.req0 = 1'b0; bus.req1 = 1'b0;
      end
      if (bus.done) begin
        dcyc = cyc; r = bus.result; c = bus.cout; o = bus.owner;
      end else if (bus.result !== prev_r || bus.cout !== prev_c || bus.owner !== prev_o) begin
        viol++;
      end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    tick();
    if (bus.busy) bcnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req0 = 1'b0; bus.a0 = 8'h00; bus.b0 = 8'h00;
    bus.req1 = 1'b0; bus.a1 = 8'h00; bus.b1 = 8'h00;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    total++; if ({bus.gnt0, bus.gnt1} !== 2'b00) begin bad++; $display("FAIL reset_gnt got=%b exp=00", {bus.gnt0, bus.gnt1}); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    total++; if (bus.result !== 8'h00) begin bad++; $display("FAIL reset_result got=%h exp=00", bus.result); end
    total++; if ({bus.cout, bus.owner} !== 2'b00) begin bad++; $display("FAIL reset_cout_owner got=%b exp=00", {bus.cout, bus.owner}); end
  endtask

  task automatic test_single();
    logic [7:0] r; logic c, o, gs; int gcyc, dcyc, bcnt, viol;
    do_op(1'b0, 8'h5a, 8'h33, r, c, o, gs, gcyc, dcyc, bcnt, viol);
    total++; if (gcyc !== 1 || gs !== 1'b0) begin bad++; $display("FAIL single_gnt got cyc=%0d side=%b exp cyc=1 side=0", gcyc, gs); end
    total++; if (dcyc !== 9) begin bad++; $display("FAIL single_done_cycle got=%0d exp=9", dcyc); end
    total++; if (r !== 8'h8d) begin bad++; $display("FAIL single_result got=%h exp=8d", r); end
    total++; if ({c, o} !== 2'b00) begin bad++; $display("FAIL single_cout_owner got=%b exp=00", {c, o}); end
    total++; if (bcnt !== 9) begin bad++; $display("FAIL single_busy_cycles got=%0d exp=9", bcnt); end
    total++; if (viol !== 0) begin bad++; $display("FAIL single_invariants got=%0d exp=0", viol); end
  endtask

  task automatic test_overflow();
    logic [7:0] r; logic c, o, gs; int gcyc, dcyc, bcnt, viol;
    do_op(1'b1, 8'hff, 8'h01, r, c, o, gs, gcyc, dcyc, bcnt, viol);
    total++; if (r !== 8'h00 || c !== 1'b1 || o !== 1'b1 || dcyc !== 9) begin
      bad++; $display("FAIL ovf_ff_01 got r=%h c=%b o=%b d=%0d exp r=00 c=1 o=1 d=9", r, c, o, dcyc); end
    do_op(1'b1, 8'h80, 8'h80, r, c, o, gs, gcyc, dcyc, bcnt, viol);
    total++; if (r !== 8'h00 || c !== 1'b1 || o !== 1'b1 || dcyc !== 9) begin
      bad++; $display("FAIL ovf_80_80 got r=%h c=%b o=%b d=%0d exp r=00 c=1 o=1 d=9", r, c, o, dcyc); end
    do_op(1'b1, 8'h00, 8'h00, r, c, o, gs, gcyc, dcyc, bcnt, viol);
    total++; if (r !== 8'h00 || c !== 1'b0 || o !== 1'b1 || dcyc !== 9) begin
      bad++; $display("FAIL ovf_00_00 got r=%h c=%b o=%b d=%0d exp r=00 c=0 o=1 d=9", r, c, o, dcyc); end
  endtask

  task automatic test_round_robin();
    int gn = 0; int dn = 0; int both = 0;
    int gcy[4]; logic gsd[4]; logic [7:0] dres[4]; logic down[4];
    logic [7:0] er;
    rst = 1'b1; tick(); rst = 1'b0;
    bus.req0 = 1'b1; bus.a0 = 8'h01; bus.b0 = 8'h02;
    bus.req1 = 1'b1; bus.a1 = 8'h03; bus.b1 = 8'h04;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      tick();
      if (bus.gnt0 && bus.gnt1) both++;
      if ((bus.gnt0 || bus.gnt1) && gn < 4) begin gcy[gn] = cyc; gsd[gn] = bus.gnt1; gn++; end
      if (bus.done && dn < 4) begin dres[dn] = bus.result; down[dn] = bus.owner; dn++; end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    tick(); tick();
    total++; if (gn !== 4 || dn !== 4) begin bad++; $display("FAIL rr_counts got gnts=%0d dones=%0d exp 4 4", gn, dn); end
    total++; if (both !== 0) begin bad++; $display("FAIL rr_gnt_exclusive got=%0d exp=0", both); end
    for (int k = 0; k < 4; k++) begin
      er = k[0] ? 8'h07 : 8'h03;
      total++; if (gsd[k] !== k[0]) begin bad++; $display("FAIL rr_gnt_side[%0d] got=%b exp=%b", k, gsd[k], k[0]); end
      total++; if (down[k] !== k[0]) begin bad++; $display("FAIL rr_owner[%0d] got=%b exp=%b", k, down[k], k[0]); end
      total++; if (dres[k] !== er) begin bad++; $display("FAIL rr_result[%0d] got=%h exp=%h", k, dres[k], er); end
    end
    for (int k = 1; k < 4; k++) begin
      total++; if (gcy[k] - gcy[k-1] !== 10) begin bad++; $display("FAIL rr_spacing[%0d] got=%0d exp=10", k, gcy[k] - gcy[k-1]); end
    end
  endtask

  task automatic test_ignored_request();
    int g0 = -1; int g1 = -1; int d0 = -1; int d1 = -1;
    logic [7:0] r0 = 8'h00; logic [7:0] r1 = 8'h00; logic o0 = 1'b0; logic o1 = 1'b0;
    bus.req0 = 1'b1; bus.a0 = 8'h10; bus.b0 = 8'h20;
    for (int cyc = 1; cyc <= 25; cyc++) begin
      tick();
      if (bus.gnt0 && g0 < 0) begin g0 = cyc; bus.req0 = 1'b0; end
      if (bus.gnt1 && g1 < 0) begin g1 = cyc; bus.req1 = 1'b0; end
      if (bus.done) begin
        if (d0 < 0) begin d0 = cyc; r0 = bus.result; o0 = bus.owner; end
        else if (d1 < 0) begin d1 = cyc; r1 = bus.result; o1 = bus.owner; end
      end
      if (cyc == 3) begin bus.req1 = 1'b1; bus.a1 = 8'h01; bus.b1 = 8'h02; end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    total++; if (g0 !== 1) begin bad++; $display("FAIL ign_gnt0_cycle got=%0d exp=1", g0); end
    total++; if (g1 !== 11) begin bad++; $display("FAIL ign_gnt1_cycle got=%0d exp=11", g1); end
    total++; if (d0 !== 9 || r0 !== 8'h30 || o0 !== 1'b0) begin
      bad++; $display("FAIL ign_first_done got d=%0d r=%h o=%b exp d=9 r=30 o=0", d0, r0, o0); end
    total++; if (d1 !== 19 || r1 !== 8'h03 || o1 !== 1'b1) begin
      bad++; $display("FAIL ign_second_done got d=%0d r=%h o=%b exp d=19 r=03 o=1", d1, r1, o1); end
  endtask

  task automatic test_reset_midop();
    int dcount = 0; int bcount = 0; int dc = -1;
    logic [7:0] r = 8'h00; logic o = 1'b1;
    bus.req0 = 1'b1; bus.a0 = 8'h11; bus.b0 = 8'h22;
    tick();
    bus.req0 = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if ({bus.busy, bus.done, bus.gnt0, bus.gnt1} !== 4'b0000) begin
      bad++; $display("FAIL rstmid_ctrl got busy,done,gnt0,gnt1=%b exp=0000", {bus.busy, bus.done, bus.gnt0, bus.gnt1}); end
    total++; if (bus.result !== 8'h00 || bus.owner !== 1'b0) begin
      bad++; $display("FAIL rstmid_result got r=%h o=%b exp r=00 o=0", bus.result, bus.owner); end
    for (int cyc = 0; cyc < 15; cyc++) begin
      tick();
      if (bus.done) dcount++;
      if (bus.busy || bus.gnt0 || bus.gnt1) bcount++;
    end
    total++; if (dcount !== 0 || bcount !== 0) begin
      bad++; $display("FAIL rstmid_quiet got dones=%0d active=%0d exp 0 0", dcount, bcount); end
    bus.req0 = 1'b1; bus.a0 = 8'h01; bus.b0 = 8'h02;
    bus.req1 = 1'b1; bus.a1 = 8'h03; bus.b1 = 8'h04;
    tick();
    total++; if ({bus.gnt0, bus.gnt1} !== 2'b10) begin
      bad++; $display("FAIL rstmid_tie_gnt got gnt0,gnt1=%b exp=10", {bus.gnt0, bus.gnt1}); end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    for (int cyc = 2; cyc <= 12 && dc < 0; cyc++) begin
      tick();
      if (bus.done) begin dc = cyc; r = bus.result; o = bus.owner; end
    end
    tick(); tick();
    total++; if (dc !== 9 || r !== 8'h03 || o !== 1'b0) begin
      bad++; $display("FAIL rstmid_tie_done got d=%0d r=%h o=%b exp d=9 r=03 o=0", dc, r, o); end
  endtask

  task automatic test_random();
    logic [7:0] a, b, r; logic c, o, gs, sel; logic [8:0] exp_sum;
    int gcyc, dcyc, bcnt, viol;
    for (int n = 0; n < 1000; n++) begin
      sel = 1'($urandom_range(0, 1));
      a   = 8'($urandom_range(0, 255));
      b   = 8'($urandom_range(0, 255));
      exp_sum = {1'b0, a} + {1'b0, b};
      do_op(sel, a, b, r, c, o, gs, gcyc, dcyc, bcnt, viol);
      total++; if ({c, r} !== exp_sum) begin
        bad++; $display("FAIL rand_sum[%0d] %h+%h got=%h exp=%h", n, a, b, {c, r}, exp_sum); end
      total++; if (o !== sel || gs !== sel) begin
        bad++; $display("FAIL rand_owner[%0d] got o=%b g=%b exp=%b", n, o, gs, sel); end
      total++; if (gcyc !== 1 || dcyc !== 9 || bcnt !== 9) begin
        bad++; $display("FAIL rand_timing[%0d] got g=%0d d=%0d busy=%0d exp 1 9 9", n, gcyc, dcyc, bcnt); end
      total++; if (viol !== 0) begin
        bad++; $display("FAIL rand_invariants[%0d] got=%0d exp=0", n, viol); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_round_robin();
    test_ignored_request();
    test_reset_midop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/serial_add_arb.md
# serial_add_arb

Bit-serial adder controller that shares one full-adder slice between two requesters. The slice is built from two half adders and an OR gate. The block arbitrates between the requesters round-robin, captures the winner's operands, and sequences the slice LSB-first over WIDTH cycles. It returns the sum, the carry-out and the owner ID with a one-cycle done strobe. It sits between the two requesting units and the shared adder datapath.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req0  in  1  requester 0 request (level)
- a0, b0  in  WIDTH  requester 0 operands
- req1  in  1  requester 1 request (level)
- a1, b1  in  WIDTH  requester 1 operands
- gnt0  out  1  one-cycle pulse: requester 0 operands captured
- gnt1  out  1  one-cycle pulse: requester 1 operands captured
- busy  out  1  high while the adder is owned (ADD and DONE states)
- done  out  1  one-cycle pulse: result/cout/owner valid
- result  out  WIDTH  sum, held until the next done
- cout  out  1  carry-out of bit WIDTH-1, held with result
- owner  out  1  requester index of the current result, held with result

## Operation
- State machine: IDLE, ADD, DONE. Reset puts it in IDLE.
- Reset values:
  - All outputs 0.
  - Carry, bit counter and shift registers 0.
  - Round-robin pointer set so req0 wins the first tie.
- IDLE:
  - If no req is high, stay in IDLE.
  - If only one req is high, grant it.
  - If both are high, grant the requester not served last. Right after reset, grant req0.
- Grant edge (leaving IDLE):
  - Latch the winner's a/b into shift registers.
  - Clear carry and the bit counter.
  - Record the owner and update the pointer.
  - Register the gnt pulse for the next cycle.
  - Go to ADD.
- ADD, each cycle, with bit i = LSB of the shift registers:
  - s1 = a^b; c1 = a&b
  - sum = s1^c; c_next = c1 | (s1&c)
  - Shift sum into the result shift register from the MSB side.
  - Shift the operand registers right; increment the counter.
- Leave ADD after exactly WIDTH cycles (counter == WIDTH-1), then go to DONE.
- On entry to DONE, load result, cout and owner from the shift register, carry and recorded owner.
- DONE: done = 1 for exactly one cycle, then go to IDLE.
- result, cout and owner hold their values until the next done. They do not change at grant time.
- Arithmetic is unsigned, modulo 2^WIDTH; the overflow bit appears on cout.
- Requests arriving during ADD/DONE are ignored and not queued. A requester keeps req high until it sees its gnt, and must drop req in the gnt cycle if it has no further work.
- gnt0 and gnt1 are never high together. done and gnt are never high together.
- rst during any state:
  - Abort the operation: no done and no gnt afterwards.
  - Return to reset values, including result, cout and owner.
  - The pointer returns to favour req0.

## Timing
- Cycle 0: IDLE samples req; operands are captured at the end of cycle 0.
- Cycle 1: gnt pulse is high; busy goes high; first ADD cycle.
- Cycles 1..WIDTH: ADD.
- Cycle WIDTH+1: DONE; done high; result, cout and owner valid; busy still high.
- Cycle WIDTH+2: IDLE, busy low. A pending request can be sampled here, so its gnt is high in cycle WIDTH+3.
- Request-to-done latency is WIDTH+1 cycles. Sustained throughput is one operation per WIDTH+2 cycles.

## Test plan
All scenarios use WIDTH=8.
- Single op: req0, a0=0x5A, b0=0x33 in cycle 0 → gnt0 high in cycle 1; done high in cycle 9 with result=0x8D, cout=0, owner=0; busy high only in cycles 1–9.
- Overflow: req1, a1=0xFF, b1=0x01 → done with result=0x00, cout=1, owner=1. Then 0x80+0x80 → result=0x00, cout=1. Then 0x00+0x00 → result=0x00, cout=0.
- Tie and round-robin: after reset, both req high continuously, with (a0,b0)=(1,2) and (a1,b1)=(3,4):
  - done owners sequence 0,1,0,1
  - results 0x03, 0x07 alternating
  - consecutive gnts exactly 10 cycles apart
  - gnt0 and gnt1 never high together
- Ignored request: req1 raised at cycle 3 of a req0 op → no gnt1 before cycle 11; gnt1 in cycle 11; req0's result unaffected.
- Reset mid-op: rst in cycle 4 of an op → from the next cycle, busy=done=gnt0=gnt1=0 and result=0. No done ever appears for the aborted op. A subsequent tie grants req0.
- Random: 1000 ops with random operands and requests vs. a reference model of (a+b) mod 256 and carry; also check owner, the gnt/done exclusivity and the held-result invariants.
